// File: rtl/display_pkg.sv
// Shared definitions for the display sharing arbiter and its tick generator.
package display_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BLANK = 2'd2
  } arb_state_e;

  // Digit code that display_7_seg shows as a dark digit
  localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

  // 1 kHz tick from a 50 MHz clock
  localparam int DEFAULT_TICK_DIV = 50000;

  // Replicate one blank digit code across all four digit positions
  function automatic logic [15:0] blank_digits(input logic [3:0] code);
    return {4{code}};
  endfunction

endpackage

// File: rtl/display_tick_gen.sv
// Free-running prescaler producing a one-cycle tick pulse every TICK_DIV clocks.
module display_tick_gen
  import display_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count 0..TICK_DIV-1 and wrap; never cleared by the arbiter state
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin sharing of one 4-digit 7-segment display between N_REQ lanes,
// with a minimum hold time per owner and a blank gap on every handover.
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int         N_REQ       = 3,
  parameter int         TICK_DIV    = DEFAULT_TICK_DIV,
  parameter int         HOLD_TICKS  = 2000,
  parameter int         BLANK_TICKS = 20,
  parameter logic [3:0] BLANK_CODE  = DEFAULT_BLANK_CODE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  value,
  output logic [N_REQ-1:0]     grant,
  output logic [3:0]           units,
  output logic [3:0]           tens,
  output logic [3:0]           hundreds,
  output logic [3:0]           thousands,
  output logic                 busy
);

  localparam int               IW         = $clog2(N_REQ);
  localparam int               HOLD_EFF   = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int               HW         = $clog2(HOLD_EFF + 1);
  localparam logic [HW-1:0]    HOLD_MAX   = HW'(HOLD_EFF);
  localparam int               BW         = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [BW-1:0]    BLANK_LAST = BW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0]    LAST_LANE  = IW'(N_REQ - 1);
  localparam logic [15:0]      BLANK_WORD = blank_digits(BLANK_CODE);

  arb_state_e        state_q,  state_d;
  logic [N_REQ-1:0]  grant_q,  grant_d;
  logic [IW-1:0]     owner_q,  owner_d;
  logic [IW-1:0]     rr_q,     rr_d;
  logic [HW-1:0]     hold_q,   hold_d;
  logic [BW-1:0]     blank_q,  blank_d;
  logic [15:0]       digits_q, digits_d;
  logic              busy_q,   busy_d;

  logic              tick;
  logic [15:0]       lanes [N_REQ];
  logic [IW-1:0]     winner;
  logic [IW-1:0]     cand;
  logic [N_REQ-1:0]  owner_mask;
  logic              others_req;
  logic [IW-1:0]     next_lane;

  display_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Split the packed value bus into one 16-bit BCD word per lane
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      lanes[i] = value[16*i +: 16];
    end
  end

  // Round-robin pick: first requesting lane at or after the pointer, wrapping
  always_comb begin
    winner = rr_q;
    cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (int'(rr_q) + k >= N_REQ) cand = IW'(int'(rr_q) + k - N_REQ);
      else                         cand = IW'(int'(rr_q) + k);
      if (req[cand]) winner = cand;
    end
  end

  assign owner_mask = N_REQ'(1) << owner_q;
  assign others_req = |(req & ~owner_mask);
  assign next_lane  = (owner_q == LAST_LANE) ? '0 : owner_q + IW'(1);

  // Next-state logic for the ownership FSM and all registered outputs
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    blank_d  = blank_q;
    digits_d = digits_q;
    busy_d   = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d         = ST_GRANT;
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          busy_d          = 1'b1;
          digits_d        = lanes[winner];
          hold_d          = '0;
        end else begin
          grant_d  = '0;
          busy_d   = 1'b0;
          digits_d = BLANK_WORD;
        end
      end
      ST_GRANT: begin
        digits_d = lanes[owner_q];
        if (tick && hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
        if (!req[owner_q] || (hold_q == HOLD_MAX && others_req)) begin
          grant_d  = '0;
          rr_d     = next_lane;
          digits_d = BLANK_WORD;
          if (BLANK_TICKS > 0 && others_req) begin
            state_d = ST_BLANK;
            busy_d  = 1'b1;
            blank_d = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      ST_BLANK: begin
        grant_d  = '0;
        busy_d   = 1'b1;
        digits_d = BLANK_WORD;
        if (tick) begin
          if (blank_q == BLANK_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            blank_d = '0;
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        digits_d = BLANK_WORD;
      end
    endcase
  end

  // State and output registers; reset overrides every other input
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      hold_q   <= '0;
      blank_q  <= '0;
      digits_q <= BLANK_WORD;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      blank_q  <= blank_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign thousands = digits_q[15:12];
  assign hundreds  = digits_q[11:8];
  assign tens      = digits_q[7:4];
  assign units     = digits_q[3:0];

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with scoreboard queues of expected
// outputs and expected grant order.
module tb_display_share_arbiter;

  localparam int          N_REQ       = 3;
  localparam int          TICK_DIV    = 4;
  localparam int          HOLD_TICKS  = 3;
  localparam int          BLANK_TICKS = 1;
  localparam logic [15:0] BLANK_WORD  = 16'hFFFF;
  localparam logic [15:0] LANE0       = 16'h4321;
  localparam logic [15:0] LANE1       = 16'h1234;
  localparam logic [15:0] LANE2       = 16'h9ABC;

  logic                CLK = 1'b0;
  logic                RST;
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] value;
  logic [N_REQ-1:0]    grant;
  logic [3:0]          units;
  logic [3:0]          tens;
  logic [3:0]          hundreds;
  logic [3:0]          thousands;
  logic                busy;

  typedef struct {
    string       tag;
    logic [2:0]  grant;
    logic        busy;
    logic [15:0] digits;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] order_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  display_share_arbiter #(
    .N_REQ       (N_REQ),
    .TICK_DIV    (TICK_DIV),
    .HOLD_TICKS  (HOLD_TICKS),
    .BLANK_TICKS (BLANK_TICKS),
    .BLANK_CODE  (4'hF)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .value     (value),
    .grant     (grant),
    .units     (units),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .busy      (busy)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] shownDigits();
    return {thousands, hundreds, tens, units};
  endfunction

  function automatic logic [15:0] laneValue(input int lane);
    case (lane)
      0:       return LANE0;
      1:       return LANE1;
      default: return LANE2;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
    n_checks++;
    assert (observed >= lo && observed <= hi) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d required %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [47:0] v);
    req   = r;
    value = v;
  endtask

  task automatic expectOutput(input string tag, input logic [2:0] g, input logic b, input logic [15:0] d);
    exp_t e;
    e.tag    = tag;
    e.grant  = g;
    e.busy   = b;
    e.digits = d;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkValue("scoreboard empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkValue({e.tag, " grant"},  32'(grant),         32'(e.grant));
      checkValue({e.tag, " busy"},   32'(busy),          32'(e.busy));
      checkValue({e.tag, " digits"}, 32'(shownDigits()), 32'(e.digits));
    end
  endtask

  task automatic nextCycle();
    @(negedge CLK);
  endtask

  task automatic resetDut();
    RST = 1'b1;
    req = '0;
    nextCycle();
    RST = 1'b0;
  endtask

  task automatic waitForGrant(input string tag, input int budget, output int cycles);
    logic [2:0] exp_g;
    exp_g  = (order_q.size() != 0) ? order_q.pop_front() : 3'b000;
    cycles = 0;
    while (grant === 3'b000 && cycles < budget) begin
      nextCycle();
      cycles++;
    end
    checkValue({tag, " grant order"}, 32'(grant), 32'(exp_g));
  endtask

  task automatic waitForRelease(input string tag, input int budget, output int cycles);
    int bad;
    bad    = 0;
    cycles = 0;
    while (grant !== 3'b000 && cycles < budget) begin
      nextCycle();
      cycles++;
      if (!$onehot0(grant)) bad++;
    end
    checkValue({tag, " released"}, 32'(grant), 32'd0);
    checkValue({tag, " one-hot"},  32'(bad),   32'd0);
  endtask

  initial begin
    int c;
    int held;
    int gap;
    int bad;
    int lane;

    // Reset with all lanes requesting: reset must win
    RST = 1'b1;
    applyStimulus(3'b111, {LANE2, LANE1, LANE0});
    expectOutput("reset cycle1", 3'b000, 1'b0, BLANK_WORD);
    nextCycle();
    checkOutput();
    expectOutput("reset cycle2", 3'b000, 1'b0, BLANK_WORD);
    nextCycle();
    checkOutput();
    RST = 1'b0;
    expectOutput("reset release", 3'b001, 1'b1, LANE0);
    nextCycle();
    checkOutput();

    // Single lane ownership and digit tracking
    resetDut();
    applyStimulus(3'b010, {LANE2, 16'h1234, LANE0});
    expectOutput("single grant", 3'b010, 1'b1, 16'h1234);
    nextCycle();
    checkOutput();
    applyStimulus(3'b010, {LANE2, 16'h5678, LANE0});
    expectOutput("single follow", 3'b010, 1'b1, 16'h5678);
    nextCycle();
    checkOutput();
    applyStimulus(3'b010, {LANE2, 16'hFEDC, LANE0});
    expectOutput("single non-bcd", 3'b010, 1'b1, 16'hFEDC);
    nextCycle();
    checkOutput();
    applyStimulus(3'b000, {LANE2, 16'hFEDC, LANE0});
    expectOutput("single drop", 3'b000, 1'b0, BLANK_WORD);
    nextCycle();
    checkOutput();

    // Contention: rotation 001 -> 010 -> 100 -> 001 with hold and blank gap
    resetDut();
    applyStimulus(3'b111, {LANE2, LANE1, LANE0});
    order_q.push_back(3'b001);
    order_q.push_back(3'b010);
    order_q.push_back(3'b100);
    order_q.push_back(3'b001);
    waitForGrant("contention first", 4, c);
    checkValue("contention latency", 32'(c), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      lane = i % 3;
      waitForRelease("contention", 40, held);
      checkRange("contention hold cycles", held, 10, 13);
      expectOutput("contention blank", 3'b000, 1'b1, BLANK_WORD);
      checkOutput();
      waitForGrant("contention next", 10, gap);
      checkRange("contention gap cycles", gap, 2, 5);
      expectOutput("contention owner", 3'(1 << lane), 1'b1, laneValue(lane));
      checkOutput();
    end

    // Early release by lane 0 while lane 2 waits
    resetDut();
    applyStimulus(3'b101, {LANE2, LANE1, LANE0});
    order_q.push_back(3'b001);
    waitForGrant("early first", 4, c);
    repeat (5) nextCycle();
    expectOutput("early before drop", 3'b001, 1'b1, LANE0);
    checkOutput();
    applyStimulus(3'b100, {LANE2, LANE1, LANE0});
    expectOutput("early drop", 3'b000, 1'b1, BLANK_WORD);
    nextCycle();
    checkOutput();
    order_q.push_back(3'b100);
    waitForGrant("early next", 10, gap);
    checkRange("early gap cycles", gap, 1, 5);
    expectOutput("early owner", 3'b100, 1'b1, LANE2);
    checkOutput();

    // Sole owner keeps the display well past the hold time
    resetDut();
    applyStimulus(3'b001, {LANE2, LANE1, LANE0});
    order_q.push_back(3'b001);
    waitForGrant("sole first", 4, c);
    bad = 0;
    repeat (20 * TICK_DIV) begin
      nextCycle();
      if (grant !== 3'b001 || busy !== 1'b1 || shownDigits() !== LANE0) bad++;
    end
    checkValue("sole owner deviations", 32'(bad), 32'd0);

    // Reset during lane 1 ownership clears the pointer
    resetDut();
    applyStimulus(3'b011, {LANE2, LANE1, LANE0});
    order_q.push_back(3'b001);
    order_q.push_back(3'b010);
    waitForGrant("midreset first", 4, c);
    waitForRelease("midreset", 40, held);
    waitForGrant("midreset lane1", 10, gap);
    nextCycle();
    RST = 1'b1;
    expectOutput("midreset asserted", 3'b000, 1'b0, BLANK_WORD);
    nextCycle();
    checkOutput();
    RST = 1'b0;
    expectOutput("midreset lane0 wins", 3'b001, 1'b1, LANE0);
    nextCycle();
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
